// File: rtl/att_peso_ctrl.sv
// Sequencer for the att_peso weight update: owns the weight file and streams each weight/input pair through one att_peso unit.
// Optional bias weight at address N_ENT (input fixed to 1.0) when ATT_PESO_BIAS_EN is defined.
module att_peso_ctrl #(
  parameter int TAM   = 16,
  parameter int N_ENT = 4,
  parameter int AW    = 3,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [TAM-1:0]       d,
  input  logic [TAM-1:0]       y,
  input  logic [TAM-1:0]       u,
  input  logic [N_ENT*TAM-1:0] x,
  output logic                 busy,
  output logic                 done,
  output logic                 skipped,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [TAM-1:0]       wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [TAM-1:0]       rd_data,
  output logic                 ap_en,
  output logic [TAM-1:0]       ap_d,
  output logic [TAM-1:0]       ap_y,
  output logic [TAM-1:0]       ap_u,
  output logic [TAM-1:0]       ap_in,
  output logic [TAM-1:0]       ap_w_in,
  input  logic [TAM-1:0]       ap_w_out
);

`ifdef ATT_PESO_BIAS_EN
  localparam int N_TOT = N_ENT + 1;
  localparam logic [TAM-1:0] ONE = TAM'(16'h3C00);
`else
  localparam int N_TOT = N_ENT;
`endif
  localparam int DEPTH = 1 << AW;
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [AW-1:0] LAST    = AW'(N_TOT - 1);
  localparam logic [CW-1:0] CNT_RLD = CW'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TAM-1:0]       d_q, d_d, y_q, y_d, u_q, u_d;
  logic [N_ENT*TAM-1:0] x_q, x_d;
  logic                 skipped_q, skipped_d;
  logic [TAM-1:0]       w_q [DEPTH];
  logic [TAM-1:0]       w_d [DEPTH];
  logic [TAM-1:0]       op_in [DEPTH];

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < N_TOT;
  endfunction

  // Operand input per address; unused addresses read as zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) op_in[i] = '0;
    for (int i = 0; i < N_ENT; i++) op_in[i] = x_q[i*TAM +: TAM];
`ifdef ATT_PESO_BIAS_EN
    op_in[N_ENT] = ONE;
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    y_d       = y_q;
    u_d       = u_q;
    x_d       = x_q;
    skipped_d = skipped_q;
    for (int i = 0; i < DEPTH; i++) w_d[i] = w_q[i];

    case (state_q)
      S_IDLE: begin
        // A write on the start edge commits first, so training sees the new weight.
        if (wr_en && in_range(wr_addr)) w_d[wr_addr] = wr_data;
        if (start) begin
          d_d = d;
          y_d = y;
          u_d = u;
          x_d = x;
          if (d == y) begin
            skipped_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            skipped_d = 1'b0;
            idx_d     = '0;
            cnt_d     = CNT_RLD;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          w_d[idx_q] = ap_w_out;
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = CNT_RLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      d_q       <= '0;
      y_q       <= '0;
      u_q       <= '0;
      x_q       <= '0;
      skipped_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      y_q       <= y_d;
      u_q       <= u_d;
      x_q       <= x_d;
      skipped_q <= skipped_d;
      for (int i = 0; i < DEPTH; i++) w_q[i] <= w_d[i];
    end
  end

  assign busy    = (state_q == S_ISSUE);
  assign ap_en   = (state_q == S_ISSUE);
  assign done    = (state_q == S_DONE);
  assign skipped = skipped_q;
  assign ap_d    = d_q;
  assign ap_y    = y_q;
  assign ap_u    = u_q;
  assign ap_in   = op_in[idx_q];
  assign ap_w_in = w_q[idx_q];
  assign rd_data = in_range(rd_addr) ? w_q[rd_addr] : '0;

endmodule

// File: tb/tb_att_peso_ctrl.sv
// Bench for att_peso_ctrl: two instances (LAT=1 and LAT=3) share stimulus; a transaction-level model predicts every output each cycle.
`timescale 1ns/1ps
module tb_att_peso_ctrl;
  localparam int TAM = 16, N_ENT = 4, AW = 3, NI = 2;
`ifdef ATT_PESO_BIAS_EN
  localparam int N_TOT = N_ENT + 1;
`else
  localparam int N_TOT = N_ENT;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, wr_en = 1'b0;
  logic [15:0] d = '0, y = '0, u = '0, wr_data = '0;
  logic [63:0] x = '0;
  logic [2:0]  wr_addr = '0, rd_addr = '0;

  logic        busy [NI], done [NI], skipped [NI], ap_en [NI];
  logic [15:0] rd_data [NI], ap_d [NI], ap_y [NI], ap_u [NI];
  logic [15:0] ap_in [NI], ap_w_in [NI], ap_w_out [NI];

  int checks = 0, failures = 0, cyc = 0;

  bit          act [NI];
  bit          mskip [NI];
  int          e0 [NI], span [NI];
  logic [15:0] ld [NI], ly [NI], lu [NI];
  logic [63:0] lx [NI];
  logic [15:0] wcur [NI][8], wold [NI][8], wnew [NI][8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m, r;
    e = int'(h[14:10]);
    m = real'(h[9:0]);
    if (e == 0)       r = m * (2.0 ** (-24));
    else if (e == 31) r = 131008.0;
    else              r = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e, m;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a < 2.0 ** (-14)) begin
      m = $rtoi(a * 16777216.0 + 0.5);
      return {s, 15'(m)};
    end
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    if (e >= 31) return {s, 5'h1F, 10'h0};
    return {s, 5'(e), 10'(m)};
  endfunction

  // Reference perceptron update: w + u*(d-y)*in, in half precision.
  function automatic logic [15:0] ap_fn(input logic [15:0] fd, fy, fu, fin, fw);
    return r2h(h2r(fw) + h2r(fu) * (h2r(fd) - h2r(fy)) * h2r(fin));
  endfunction

  function automatic logic [15:0] in_of(input logic [63:0] xv, input int i);
    if (i < N_ENT) return xv[i*16 +: 16];
    return 16'h3C00;
  endfunction

  function automatic logic [15:0] rand_h();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 19)), 10'($urandom)};
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, g, cyc, a, e);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    int          en_cnt;
    int          n, c, o, ix;
    bit          inrun, isdone;
    logic [15:0] erd;

    att_peso_ctrl #(.TAM(TAM), .N_ENT(N_ENT), .AW(AW), .LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .d(d), .y(y), .u(u), .x(x),
      .busy(busy[g]), .done(done[g]), .skipped(skipped[g]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data[g]),
      .ap_en(ap_en[g]), .ap_d(ap_d[g]), .ap_y(ap_y[g]), .ap_u(ap_u[g]),
      .ap_in(ap_in[g]), .ap_w_in(ap_w_in[g]), .ap_w_out(ap_w_out[g])
    );

    // Stand-in att_peso: result valid only on the last cycle of each LAT-cycle window.
    always @(posedge clk or negedge rst_n)
      if (!rst_n) en_cnt <= 0;
      else        en_cnt <= ap_en[g] ? en_cnt + 1 : 0;
    assign ap_w_out[g] = ((en_cnt % L) == (L - 1))
                         ? ap_fn(ap_d[g], ap_y[g], ap_u[g], ap_in[g], ap_w_in[g]) : 16'hDEAD;

    // Transaction model: one start yields a known window, done cycle and final weights.
    initial begin
      act[g] = 1'b0;
      for (int i = 0; i < 8; i++) wcur[g][i] = '0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          act[g] = 1'b0;
          for (int i = 0; i < 8; i++) wcur[g][i] = '0;
        end else begin
          n = cyc + 1;
          if (!act[g] || (n - 1) > e0[g] + span[g]) begin
            if (wr_en && int'(wr_addr) < N_TOT) wcur[g][wr_addr] = wr_data;
            if (start) begin
              act[g]   = 1'b1;
              e0[g]    = n;
              ld[g]    = d;
              ly[g]    = y;
              lu[g]    = u;
              lx[g]    = x;
              mskip[g] = (d === y);
              span[g]  = mskip[g] ? 0 : N_TOT * L;
              for (int i = 0; i < 8; i++) begin
                wold[g][i] = wcur[g][i];
                wnew[g][i] = (i < N_TOT && !mskip[g])
                             ? ap_fn(d, y, u, in_of(x, i), wcur[g][i]) : wcur[g][i];
                wcur[g][i] = wnew[g][i];
              end
            end
          end
        end
      end
    end

    initial forever begin
      @(negedge clk);
      c      = cyc;
      inrun  = act[g] && c >= e0[g] && c < e0[g] + span[g];
      isdone = act[g] && c == e0[g] + span[g];
      chk("busy",  g, 32'(busy[g]),  32'(inrun));
      chk("ap_en", g, 32'(ap_en[g]), 32'(inrun));
      chk("done",  g, 32'(done[g]),  32'(isdone));
      if (isdone) chk("skipped", g, 32'(skipped[g]), 32'(mskip[g]));
      if (inrun) begin
        o  = c - e0[g];
        ix = o / L;
        chk("ap_in",   g, 32'(ap_in[g]),   32'(in_of(lx[g], ix)));
        chk("ap_w_in", g, 32'(ap_w_in[g]), 32'(wold[g][ix]));
        chk("ap_d",    g, 32'(ap_d[g]),    32'(ld[g]));
        chk("ap_y",    g, 32'(ap_y[g]),    32'(ly[g]));
        chk("ap_u",    g, 32'(ap_u[g]),    32'(lu[g]));
      end
      if (int'(rd_addr) >= N_TOT)  erd = '0;
      else if (inrun)              erd = ((int'(rd_addr) + 1) * L <= c - e0[g])
                                         ? wnew[g][rd_addr] : wold[g][rd_addr];
      else                         erd = wcur[g][rd_addr];
      chk("rd_data", g, 32'(rd_data[g]), 32'(erd));
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [15:0] td, ty, tu, input logic [63:0] tx);
    d = td; y = ty; u = tu; x = tx;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(N_TOT * 3 + 3);
  endtask

  task automatic lit_w(input logic [2:0] a, input logic [15:0] e, input string nm);
    rd_addr = a;
    #1;
    for (int g = 0; g < NI; g++) chk(nm, g, 32'(rd_data[g]), 32'(e));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin rd_addr = 3'(a); step(1); end

    chk("fn_pin_one", 0, 32'(ap_fn(16'h3C00, 16'hBC00, 16'h3800, 16'h3C00, 16'h0000)), 32'h3C00);
    chk("fn_pin_1p5", 0, 32'(ap_fn(16'h3C00, 16'hBC00, 16'h3800, 16'h3C00, 16'h3800)), 32'h3E00);

    run(16'h3C00, 16'hBC00, 16'h3800, {4{16'h3C00}});
    for (int a = 0; a < N_TOT; a++) lit_w(3'(a), 16'h3C00, "w_after_run1");

    run(16'h3C00, 16'h3C00, 16'h3800, {4{16'h3C00}});

    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h3800;
    step(1);
    wr_en = 1'b0;
    run(16'h3C00, 16'hBC00, 16'h3800, {4{16'h3C00}});
    lit_w(3'd2, 16'h3E00, "w2_preloaded");
    lit_w(3'd0, 16'h4000, "w0_second_run");

    run(16'h0000, 16'h8000, 16'h3800, {4{16'h3C00}});

    d = 16'h3C00; y = 16'hBC00; u = 16'h2C00; start = 1'b1;
    step(1);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234;
    step(2);
    wr_en = 1'b0; start = 1'b0;
    step(N_TOT * 3 + 2);

    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h4400;
    run(16'h4000, 16'h3C00, 16'h3400, {16'h3C00, 16'hBC00, 16'h3800, 16'h4000});
    wr_en = 1'b0;

    d = 16'h3C00; y = 16'hBC00; u = 16'h3800; start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    lit_w(3'd2, 16'h0000, "w2_after_reset");
    for (int a = 0; a < 8; a++) begin rd_addr = 3'(a); step(1); end

    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = 3'($urandom_range(0, 7));
        wr_data = rand_h();
        rd_addr = 3'($urandom_range(0, 7));
        step(1);
      end
      d = rand_h();
      case ($urandom_range(0, 3))
        0:       y = d;
        1:       y = d ^ 16'h8000;
        default: y = rand_h();
      endcase
      u = rand_h();
      x = {rand_h(), rand_h(), rand_h(), rand_h()};
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = rand_h();
      start   = 1'b1;
      step(1);
      start = 1'b0;
      wr_en = 1'b0;
      for (int k = 0; k < N_TOT * 3 + 2; k++) begin
        rd_addr = 3'($urandom_range(0, 7));
        start   = ($urandom_range(0, 7) == 0);
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 3'($urandom_range(0, 7));
        wr_data = rand_h();
        step(1);
      end
      start = 1'b0;
      wr_en = 1'b0;
      step(2);
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
